stereo_matrix_out: RTL and testbench

STEREO_MATRIX_OUT -- requirements
Module: stereo_matrix_out

---
 rtl/stereo_matrix_out.sv | 136 +++++++++++++
 tb/tb_stereo_matrix_out.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/stereo_matrix_out.sv
// Stereo L/R matrix decoder: (sum,diff) -> gained L/R pairs into an output FIFO; STEREO_MATRIX_SAT_EN selects clamping.
// Latency 3 cycles pop-to-out_valid, one pair per 3 cycles; sources are not popped while the output FIFO is full.
module stereo_matrix_out #(
    parameter int DATA_WIDTH = 32,
    parameter int FRAC_BITS  = 10,
    parameter int OUT_DEPTH  = 16
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [DATA_WIDTH-1:0]       sum_in,
    input  logic                        sum_valid,
    output logic                        sum_rd_en,
    input  logic [DATA_WIDTH-1:0]       diff_in,
    input  logic                        diff_valid,
    output logic                        diff_rd_en,
    input  logic [DATA_WIDTH-1:0]       vol_left,
    input  logic [DATA_WIDTH-1:0]       vol_right,
    input  logic                        mute,
    output logic [DATA_WIDTH-1:0]       left_out,
    output logic [DATA_WIDTH-1:0]       right_out,
    output logic                        out_valid,
    input  logic                        out_rd_en,
    output logic [$clog2(OUT_DEPTH):0]  out_count,
    output logic                        sat_flag
);

    localparam int AW = $clog2(OUT_DEPTH);
    localparam int CW = AW + 1;
    localparam int PW = 2 * DATA_WIDTH + 1;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADD  = 2'd1;
    localparam logic [1:0] ST_GAIN = 2'd2;
    localparam logic [CW-1:0] DEPTH_C = CW'(OUT_DEPTH);

    logic [1:0]                   state_q, state_d;
    logic [DATA_WIDTH-1:0]        s_q, d_q;
    logic signed [DATA_WIDTH:0]   l_q, r_q;
    logic [DATA_WIDTH-1:0]        mem_l [OUT_DEPTH];
    logic [DATA_WIDTH-1:0]        mem_r [OUT_DEPTH];
    logic [AW-1:0]                wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]                count_q;
    logic                         pop_in, wr_en, rd_en;
    logic signed [PW-1:0]         prod_l, prod_r, sh_l, sh_r;
    logic [DATA_WIDTH-1:0]        res_l, res_r;

    assign pop_in     = (state_q == ST_IDLE) && sum_valid && diff_valid &&
                        (count_q < DEPTH_C) && !reset;
    assign sum_rd_en  = pop_in;
    assign diff_rd_en = pop_in;
    assign wr_en      = (state_q == ST_GAIN) && !reset;
    assign rd_en      = out_rd_en && (count_q != '0) && !reset;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (pop_in) state_d = ST_ADD;
            ST_ADD:  state_d = ST_GAIN;
            default: state_d = ST_IDLE;
        endcase
    end

    // Full-precision products; >>> on a signed value gives floor division.
    always_comb begin
        prod_l = PW'(l_q) * PW'($signed(vol_left));
        prod_r = PW'(r_q) * PW'($signed(vol_right));
        sh_l   = prod_l >>> FRAC_BITS;
        sh_r   = prod_r >>> FRAC_BITS;
    end

`ifdef STEREO_MATRIX_SAT_EN
    localparam logic signed [DATA_WIDTH-1:0] DMAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [DATA_WIDTH-1:0] DMIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    logic hi_l, lo_l, hi_r, lo_r, sat_q;

    assign hi_l  = sh_l > PW'(DMAX);
    assign lo_l  = sh_l < PW'(DMIN);
    assign hi_r  = sh_r > PW'(DMAX);
    assign lo_r  = sh_r < PW'(DMIN);
    assign res_l = mute ? '0 : hi_l ? DMAX : lo_l ? DMIN : sh_l[DATA_WIDTH-1:0];
    assign res_r = mute ? '0 : hi_r ? DMAX : lo_r ? DMIN : sh_r[DATA_WIDTH-1:0];

    always_ff @(posedge clock) begin
        if (reset)
            sat_q <= 1'b0;
        else if (wr_en && !mute && (hi_l || lo_l || hi_r || lo_r))
            sat_q <= 1'b1;
    end
    assign sat_flag = sat_q;
`else
    logic unused_hi;

    assign res_l     = mute ? '0 : sh_l[DATA_WIDTH-1:0];
    assign res_r     = mute ? '0 : sh_r[DATA_WIDTH-1:0];
    assign unused_hi = ^{sh_l[PW-1:DATA_WIDTH], sh_r[PW-1:DATA_WIDTH]};
    assign sat_flag  = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            s_q      <= '0;
            d_q      <= '0;
            l_q      <= '0;
            r_q      <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q <= state_d;
            if (pop_in) begin
                s_q <= sum_in;
                d_q <= diff_in;
            end
            if (state_q == ST_ADD) begin
                l_q <= $signed({s_q[DATA_WIDTH-1], s_q}) + $signed({d_q[DATA_WIDTH-1], d_q});
                r_q <= $signed({s_q[DATA_WIDTH-1], s_q}) - $signed({d_q[DATA_WIDTH-1], d_q});
            end
            if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (rd_en) rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + CW'(wr_en) - CW'(rd_en);
        end
    end

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem_l[wr_ptr_q] <= res_l;
            mem_r[wr_ptr_q] <= res_r;
        end
    end

    assign out_valid = (count_q != '0);
    assign out_count = count_q;
    assign left_out  = out_valid ? mem_l[rd_ptr_q] : '0;
    assign right_out = out_valid ? mem_r[rd_ptr_q] : '0;

endmodule

// File: tb/tb_stereo_matrix_out.sv
// Randomized + directed bench for stereo_matrix_out against a queue-based reference model.
module tb_stereo_matrix_out;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] sum_in, diff_in, vol_left, vol_right;
    logic        sum_valid, diff_valid, mute, out_rd_en;
    logic        sum_rd_en, diff_rd_en, out_valid, sat_flag;
    logic [31:0] left_out, right_out;
    logic [4:0]  out_count;

    stereo_matrix_out dut (
        .clock(clock), .reset(reset),
        .sum_in(sum_in), .sum_valid(sum_valid), .sum_rd_en(sum_rd_en),
        .diff_in(diff_in), .diff_valid(diff_valid), .diff_rd_en(diff_rd_en),
        .vol_left(vol_left), .vol_right(vol_right), .mute(mute),
        .left_out(left_out), .right_out(right_out), .out_valid(out_valid),
        .out_rd_en(out_rd_en), .out_count(out_count), .sat_flag(sat_flag)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Reference model state
    logic [63:0] fifo_q[$];
    int          cyc       = 0;
    int          last_pop  = -100;
    int          pend_gain = 0;
    bit          pend_v    = 1'b0;
    logic [31:0] pend_s, pend_d;
    bit          sat_m     = 1'b0;
    bit          last_rd   = 1'b0;

    function automatic logic [31:0] gain_ref(input logic [31:0] a, input logic [31:0] b,
                                             input bit neg, input logic [31:0] v,
                                             output bit clip);
        logic signed [79:0] x, y, vv, p, q;
`ifdef STEREO_MATRIX_SAT_EN
        logic signed [79:0] maxv, minv;
`endif
        x    = $signed(a);
        y    = $signed(b);
        x    = neg ? x - y : x + y;
        vv   = $signed(v);
        p    = x * vv;
        q    = p >>> 10;
        clip = 1'b0;
`ifdef STEREO_MATRIX_SAT_EN
        maxv = 80'sd2147483647;
        minv = -maxv - 80'sd1;
        if (q > maxv) begin clip = 1'b1; q = maxv; end
        else if (q < minv) begin clip = 1'b1; q = minv; end
`endif
        return q[31:0];
    endfunction

    // One clock cycle: check registered outputs, drive inputs, check pops, advance model.
    task automatic cyc_step(input bit rst, input bit sv, input bit dv,
                            input logic [31:0] s, input logic [31:0] d,
                            input logic [31:0] vl, input logic [31:0] vr,
                            input bit m, input bit ord);
        bit          exp_rd, do_rd, do_wr, set_sat, c1, c2;
        logic [31:0] wl, wr;
        check("count", {59'd0, out_count}, 64'(fifo_q.size()));
        check("valid", {63'd0, out_valid}, {63'd0, fifo_q.size() != 0});
        if (fifo_q.size() != 0) check("head", {left_out, right_out}, fifo_q[0]);
        check("sat", {63'd0, sat_flag}, {63'd0, sat_m});

        reset = rst; sum_valid = sv; diff_valid = dv; sum_in = s; diff_in = d;
        vol_left = vl; vol_right = vr; mute = m; out_rd_en = ord;
        #1;
        exp_rd = !rst && sv && dv && (cyc - last_pop >= 3) && (fifo_q.size() < 16);
        last_rd = sum_rd_en;
        check("sum_rd_en", {63'd0, sum_rd_en}, {63'd0, exp_rd});
        check("diff_rd_en", {63'd0, diff_rd_en}, {63'd0, exp_rd});

        do_rd = 1'b0; do_wr = 1'b0; set_sat = 1'b0; wl = '0; wr = '0;
        if (!rst) begin
            do_rd = ord && (fifo_q.size() != 0);
            if (pend_v && pend_gain == cyc) begin
                do_wr  = 1'b1;
                pend_v = 1'b0;
                if (!m) begin
                    wl = gain_ref(pend_s, pend_d, 1'b0, vl, c1);
                    wr = gain_ref(pend_s, pend_d, 1'b1, vr, c2);
                    set_sat = c1 | c2;
                end
            end
            if (exp_rd) begin
                pend_v = 1'b1; pend_s = s; pend_d = d;
                pend_gain = cyc + 2; last_pop = cyc;
            end
        end

        @(posedge clock);
        #1;
        cyc++;
        if (rst) begin
            fifo_q.delete();
            pend_v = 1'b0; sat_m = 1'b0; last_pop = -100;
        end else begin
            if (do_rd) void'(fifo_q.pop_front());
            if (do_wr) fifo_q.push_back({wl, wr});
            if (set_sat) sat_m = 1'b1;
        end
    endtask

    task automatic idle(input int n, input logic [31:0] vl);
        repeat (n) cyc_step(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, vl, 32'd1024, 1'b0, 1'b0);
    endtask

    task automatic drain();
        repeat (20) cyc_step(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd1024, 32'd1024, 1'b0, 1'b1);
    endtask

    initial begin
        reset = 1'b1; sum_valid = 1'b1; diff_valid = 1'b1; sum_in = 32'd1; diff_in = 32'd2;
        vol_left = 32'd1024; vol_right = 32'd1024; mute = 1'b0; out_rd_en = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check("rst_valid", {63'd0, out_valid}, 64'd0);
        check("rst_count", {59'd0, out_count}, 64'd0);
        check("rst_out", {left_out, right_out}, 64'd0);
        check("rst_sat", {63'd0, sat_flag}, 64'd0);
        check("rst_rd_en", {63'd0, sum_rd_en}, 64'd0);

        // Basic pair and latency
        cyc_step(1'b0, 1'b1, 1'b1, 32'd100, 32'd40, 32'd1024, 32'd1024, 1'b0, 1'b0);
        idle(1, 32'd1024);
        check("lat_not_yet", {63'd0, out_valid}, 64'd0);
        idle(1, 32'd1024);
        check("lat_valid", {63'd0, out_valid}, 64'd1);
        check("basic_left", {32'd0, left_out}, 64'd140);
        check("basic_right", {32'd0, right_out}, 64'd60);
        drain();

        // Floor rounding on negative product
        cyc_step(1'b0, 1'b1, 1'b1, 32'hFFFF_FFF9, 32'd0, 32'd512, 32'd1024, 1'b0, 1'b0);
        idle(2, 32'd512);
        check("floor_left", {32'd0, left_out}, {32'd0, 32'hFFFF_FFFC});
        check("floor_right", {32'd0, right_out}, {32'd0, 32'hFFFF_FFF9});
        drain();

        // Overflow boundary
        cyc_step(1'b0, 1'b1, 1'b1, 32'h7FFF_FFFF, 32'd1, 32'd1024, 32'd1024, 1'b0, 1'b0);
        idle(2, 32'd1024);
`ifdef STEREO_MATRIX_SAT_EN
        check("ovf_left", {32'd0, left_out}, {32'd0, 32'h7FFF_FFFF});
        check("ovf_sat", {63'd0, sat_flag}, 64'd1);
`else
        check("ovf_left", {32'd0, left_out}, {32'd0, 32'h8000_0000});
        check("ovf_sat", {63'd0, sat_flag}, 64'd0);
`endif
        check("ovf_right", {32'd0, right_out}, {32'd0, 32'h7FFF_FFFE});
        drain();

        // Fill to full, then free one slot
        repeat (60) cyc_step(1'b0, 1'b1, 1'b1, $urandom, $urandom, 32'd1024, 32'd1024, 1'b0, 1'b0);
        check("full_count", {59'd0, out_count}, 64'd16);
        check("full_no_pop", {63'd0, sum_rd_en}, 64'd0);
        cyc_step(1'b0, 1'b1, 1'b1, 32'd7, 32'd3, 32'd1024, 32'd1024, 1'b0, 1'b1);
        cyc_step(1'b0, 1'b1, 1'b1, 32'd9, 32'd4, 32'd1024, 32'd1024, 1'b0, 1'b0);
        check("refill_pop", {63'd0, last_rd}, 64'd1);
        idle(2, 32'd1024);
        check("refill_count", {59'd0, out_count}, 64'd16);
        drain();

        // One source valid only
        repeat (20) cyc_step(1'b0, 1'b1, 1'b0, 32'd5, 32'd5, 32'd1024, 32'd1024, 1'b0, 1'b0);
        check("half_valid", {63'd0, out_valid}, 64'd0);
        cyc_step(1'b0, 1'b1, 1'b1, 32'd5, 32'd5, 32'd1024, 32'd1024, 1'b0, 1'b0);
        check("both_valid_pop", {63'd0, last_rd}, 64'd1);
        idle(3, 32'd1024);
        drain();

        // Reset while the pair sits in GAIN
        cyc_step(1'b0, 1'b1, 1'b1, 32'd5, 32'd3, 32'd1024, 32'd1024, 1'b0, 1'b0);
        idle(1, 32'd1024);
        cyc_step(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 32'd1024, 32'd1024, 1'b0, 1'b0);
        check("gainrst_valid", {63'd0, out_valid}, 64'd0);
        check("gainrst_count", {59'd0, out_count}, 64'd0);
        cyc_step(1'b0, 1'b1, 1'b1, 32'd10, 32'd2, 32'd1024, 32'd1024, 1'b0, 1'b0);
        idle(2, 32'd1024);
        check("after_rst_left", {32'd0, left_out}, 64'd12);
        check("after_rst_right", {32'd0, right_out}, 64'd8);
        drain();

        // Randomized traffic
        repeat (600) begin
            logic [31:0] s, d, vl, vr;
            int          k;
            s  = ($urandom % 2 == 0) ? $urandom : 32'($signed($urandom_range(0, 2000)) - 1000);
            d  = ($urandom % 2 == 0) ? $urandom : 32'($signed($urandom_range(0, 2000)) - 1000);
            k  = $urandom % 4;
            vl = (k == 0) ? $urandom : (k == 1) ? 32'($urandom_range(0, 2048)) :
                 (k == 2) ? 32'(-$signed($urandom_range(0, 2048))) : 32'd1024;
            vr = ($urandom % 3 == 0) ? $urandom : 32'($urandom_range(0, 2048));
            cyc_step(($urandom % 100) == 0, ($urandom % 10) < 7, ($urandom % 10) < 7,
                     s, d, vl, vr, ($urandom % 10) == 0, ($urandom % 2) == 0);
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
